msg_fsm_sequencer: RTL
======================

// Module: msg_fsm_sequencer
// PURPOSE
//   Controller that sequences the 8-bit message FSM. It turns a raw push-button,
//   or an internal auto-advance timer, into clean single-cycle advance pulses on
//   the FSM's M input. It captures each character the FSM presents on msj_f and
//   counts characters up to MSG_LEN. It resets the message FSM on power-up and
//   on restart requests. It sits between the board I/O and the FSM instance.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive equal synced samples needed to accept a btn level
//   AUTO_PERIOD      16  clk cycles between auto-advance events (>=2)
//   MSG_LEN          6   characters per message (>=1)
//   SETTLE           1   cycles waited after m_adv before sampling msj_f (>=1)
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   rst         in   1   asynchronous, active-LOW reset
//   btn         in   1   raw asynchronous push-button
//   auto_en     in   1   1 = auto-advance timer enabled
//   restart     in   1   synchronous restart request (level, sampled each cycle)
//   msj_f       in   8   current character from message FSM
//   m_adv       out  1   advance pulse to FSM M input, exactly 1 cycle wide
//   fsm_rst     out  1   active-high reset to message FSM, exactly 1 cycle wide
//   char_out    out  8   last captured character
//   char_valid  out  1   1-cycle strobe: char_out updated this cycle
//   char_idx    out  clog2(MSG_LEN+1)  characters captured since last clear
//   msg_done    out  1   level: MSG_LEN characters captured
// BEHAVIOUR
//   Reset (rst=0): all outputs 0, counters 0, sync/debounce regs 0, state CLEAR.
//   First cycle after rst release: state CLEAR -> fsm_rst=1 for that cycle.
//   Button path: 2-FF synchronizer, then debounce counter. A level is accepted
//     after DEBOUNCE_CYCLES equal samples. A 0->1 accepted transition gives btn_evt (1 cycle).
//   Auto timer: counts only when auto_en=1 and state=IDLE, else held at 0.
//     At AUTO_PERIOD-1 it gives auto_evt and wraps to 0.
//   States:
//     IDLE:    restart -> CLEAR (priority); else btn_evt|auto_evt -> ADVANCE.
//     ADVANCE: m_adv=1 -> SETTLE.
//     SETTLE:  wait SETTLE cycles -> CAPTURE.
//     CAPTURE: char_out<=msj_f, char_valid=1, char_idx+=1.
//              -> DONE if new char_idx==MSG_LEN, else IDLE.
//     DONE:    msg_done=1; btn/auto events ignored; restart -> CLEAR.
//     CLEAR:   fsm_rst=1; char_idx<=0, char_out<=0, msg_done<=0 -> IDLE.
//   Latency: event seen in IDLE at edge t -> m_adv high in cycle t+1.
//     char_valid high in cycle t+2+SETTLE.
//   Events arriving outside IDLE are dropped, never queued.
//   restart during ADVANCE/SETTLE/CAPTURE is latched as pending. The current
//     capture still completes; pending restart then forces CLEAR from IDLE or DONE.
//   Simultaneous btn_evt and auto_evt: a single advance.
//   char_idx never exceeds MSG_LEN, no wrap. Only CLEAR returns it to 0.
//   Async reset mid-sequence: immediate return to reset values, then CLEAR.
//   m_adv and fsm_rst are never high in the same cycle.
// TESTING
//   1 Reset release -> fsm_rst one cycle high, then IDLE. All other outputs 0.
//   2 btn held 1 for 3 cycles (DEBOUNCE_CYCLES=4) -> no m_adv.
//     btn held 6 cycles -> exactly one m_adv.
//   3 Six accepted presses, msj_f=8'h48 on each capture -> char_valid x6.
//     char_idx 1..6, msg_done=1. A seventh press gives no m_adv.
//   4 auto_en=1, AUTO_PERIOD=16 -> m_adv every 16+SETTLE+2 cycles until msg_done.
//     auto_en=0 mid-run -> no further m_adv.
//   5 restart asserted in SETTLE -> capture completes (char_valid).
//     Next cycle CLEAR: fsm_rst=1, char_idx=0, msg_done=0.
//   6 rst pulsed low during ADVANCE -> m_adv drops at once.
//     After release: fsm_rst pulse, char_idx=0.

Source files
------------

// File: rtl/msg_fsm_sequencer.sv
// Message FSM sequencer: debounced button / auto timer to single advance
// pulses, character capture and counting, and message FSM reset control.
module msg_fsm_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 16,
    parameter int MSG_LEN         = 6,
    parameter int SETTLE          = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn,
    input  logic                         auto_en,
    input  logic                         restart,
    input  logic [7:0]                   msj_f,
    output logic                         m_adv,
    output logic                         fsm_rst,
    output logic [7:0]                   char_out,
    output logic                         char_valid,
    output logic [$clog2(MSG_LEN+1)-1:0] char_idx,
    output logic                         msg_done
);

    localparam int IW = $clog2(MSG_LEN + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST   = AW'(AUTO_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [IW-1:0] IDX_MAX     = IW'(MSG_LEN);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ADVANCE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic          sync1;
    logic          sync2;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic [AW-1:0] auto_cnt;
    logic [SW-1:0] settle_cnt;
    logic          pend;
    logic          btn_evt;
    logic          auto_evt;
    logic          timer_run;
    logic          restart_any;
    logic [IW-1:0] idx_inc;

    assign btn_evt     = sync2 & ~db_level & (db_cnt == DB_LAST);
    assign timer_run   = auto_en & (state == S_IDLE);
    assign auto_evt    = timer_run & (auto_cnt == AUTO_LAST);
    assign restart_any = restart | pend;
    assign idx_inc     = (char_idx == IDX_MAX) ? char_idx : char_idx + 1'b1;

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new button level after enough consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Auto-advance timer, only running while idle and enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt <= '0;
        end else if (!timer_run || auto_evt) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and strobe outputs
    always_comb begin
        state_nx   = state;
        m_adv      = 1'b0;
        fsm_rst    = 1'b0;
        char_valid = 1'b0;
        unique case (state)
            S_CLEAR: begin
                fsm_rst  = rst;
                state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (restart_any) begin
                    state_nx = S_CLEAR;
                end else if (btn_evt || auto_evt) begin
                    state_nx = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                m_adv    = 1'b1;
                state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                char_valid = 1'b1;
                if (restart_any) begin
                    state_nx = S_CLEAR;
                end else if (idx_inc == IDX_MAX) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_DONE: begin
                if (restart_any) begin
                    state_nx = S_CLEAR;
                end
            end
            default: state_nx = S_CLEAR;
        endcase
    end

    // Settle wait, pending restart, captured character and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
            pend       <= 1'b0;
            char_out   <= '0;
            char_idx   <= '0;
            msg_done   <= 1'b0;
        end else begin
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (state == S_CLEAR) begin
                pend <= 1'b0;
            end else if (restart &&
                         (state == S_ADVANCE || state == S_SETTLE)) begin
                pend <= 1'b1;
            end
            if (state == S_CAPTURE) begin
                char_out <= msj_f;
                char_idx <= idx_inc;
                msg_done <= (idx_inc == IDX_MAX);
            end else if (state == S_CLEAR) begin
                char_out <= '0;
                char_idx <= '0;
                msg_done <= 1'b0;
            end
        end
    end

endmodule
